// File: rtl/axi4_burst_slave_pkg.sv
// Shared encodings, FSM state types and the burst address stepping rule
// for the AXI4 burst register slave.
package axi4_burst_slave_pkg;

   localparam logic [1:0] BURST_FIXED = 2'd0;
   localparam logic [1:0] BURST_INCR  = 2'd1;
   localparam logic [1:0] BURST_WRAP  = 2'd2;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Address arithmetic is done at this width; callers zero-extend into it.
   localparam int STEP_W = 32;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } w_state_t;

   typedef enum logic {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } r_state_t;

   typedef struct packed {
      logic [STEP_W-1:0] addr;
      logic              wrap_illegal;
   } addr_step_t;

   // Next beat address at word granularity. An illegal WRAP length steps
   // like INCR and raises wrap_illegal; the reserved encoding also steps like INCR.
   function automatic addr_step_t next_word_addr(input logic [STEP_W-1:0] addr,
                                                 input logic [7:0]        len,
                                                 input logic [1:0]        burst);
      addr_step_t        res;
      logic [STEP_W-1:0] incr;
      logic [STEP_W-1:0] span;
      logic [STEP_W-1:0] bound;
      logic              legal;
      legal = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
      incr  = addr + 32'd4;
      span  = ({24'd0, len} + 32'd1) << 2;
      bound = addr & ~(span - 32'd1);
      res.wrap_illegal = (burst == BURST_WRAP) && !legal;
      res.addr = incr;
      if (burst == BURST_FIXED) begin
         res.addr = addr;
      end else if ((burst == BURST_WRAP) && legal && (incr == bound + span)) begin
         res.addr = bound;
      end
      return res;
   endfunction

endpackage

// File: rtl/axi4_burst_addr_gen.sv
// Per-channel address stepper: next beat address plus the in-memory range
// check for both the current and the next address.
module axi4_burst_addr_gen
   import axi4_burst_slave_pkg::*;
#(
   parameter int IAW   = 18,
   parameter int DEPTH = 64
) (
   input  logic [IAW-1:0] addr_i,
   input  logic [7:0]     len_i,
   input  logic [1:0]     burst_i,
   output logic [IAW-1:0] next_addr_o,
   output logic           wrap_illegal_o,
   output logic           cur_in_range_o,
   output logic           next_in_range_o
);

   addr_step_t step;

   // Step the address through the shared burst rule
   always_comb begin
      step = next_word_addr(STEP_W'(addr_i), len_i, burst_i);
   end

   assign next_addr_o     = step.addr[IAW-1:0];
   assign wrap_illegal_o  = step.wrap_illegal;
   assign cur_in_range_o  = (STEP_W'(addr_i) >> 2) < STEP_W'(DEPTH);
   assign next_in_range_o = (step.addr >> 2) < STEP_W'(DEPTH);

endmodule

// File: rtl/axi4_burst_slave.sv
// AXI4 burst slave over a DEPTH x 32 register memory. Independent write
// (AW/W/B) and read (AR/R) FSMs; all channel outputs are registered.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; ready never depends on the same channel's valid, and a valid once
// raised holds its payload stable until the transfer edge.
module axi4_burst_slave
   import axi4_burst_slave_pkg::*;
#(
   parameter int ID_WIDTH   = 4,
   parameter int ADDR_WIDTH = 8,
   parameter int DEPTH      = 64
) (
   input  logic                  clock_i,
   input  logic                  reset_i,
   input  logic [ID_WIDTH-1:0]   awid_i,
   input  logic [ADDR_WIDTH-1:0] awaddr_i,
   input  logic [7:0]            awlen_i,
   input  logic [2:0]            awsize_i,
   input  logic [1:0]            awburst_i,
   input  logic                  awvalid_i,
   output logic                  awready_o,
   input  logic [31:0]           wdata_i,
   input  logic [3:0]            wstrb_i,
   input  logic                  wlast_i,
   input  logic                  wvalid_i,
   output logic                  wready_o,
   output logic [ID_WIDTH-1:0]   bid_o,
   output logic [1:0]            bresp_o,
   output logic                  bvalid_o,
   input  logic                  bready_i,
   input  logic [ID_WIDTH-1:0]   arid_i,
   input  logic [ADDR_WIDTH-1:0] araddr_i,
   input  logic [7:0]            arlen_i,
   input  logic [2:0]            arsize_i,
   input  logic [1:0]            arburst_i,
   input  logic                  arvalid_i,
   output logic                  arready_o,
   output logic [ID_WIDTH-1:0]   rid_o,
   output logic [31:0]           rdata_o,
   output logic [1:0]            rresp_o,
   output logic                  rlast_o,
   output logic                  rvalid_o,
   input  logic                  rready_i,
   output w_state_t              w_state_o,
   output r_state_t              r_state_o
);

   // Extra headroom so a burst running past the top of the address space
   // is seen as out of range instead of wrapping back onto word 0.
   localparam int IAW   = ADDR_WIDTH + 10;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rd_word_q;

   // Write channel state
   w_state_t            w_state_q;
   logic [ID_WIDTH-1:0] wid_q;
   logic [IAW-1:0]      waddr_q;
   logic [7:0]          wlen_q, wbeat_q;
   logic [1:0]          wburst_q, bresp_q;
   logic                wdrop_q, wpast_q, werr_q;
   logic                awready_q, wready_q, bvalid_q;
   logic [IAW-1:0]      wg_addr, wg_next;
   logic [7:0]          wg_len;
   logic [1:0]          wg_burst;
   logic                wg_wrap_bad, wg_cur_in, wg_next_in_unused;
   logic                aw_drop, w_fire, w_en, w_beat_err;

   // Read channel state
   r_state_t            r_state_q;
   logic [ID_WIDTH-1:0] rid_q;
   logic [IAW-1:0]      raddr_q;
   logic [7:0]          rlen_q, rbeat_q;
   logic [1:0]          rburst_q, rresp_q;
   logic                rdrop_q, rvalid_q, rlast_q, rzero_q, arready_q;
   logic [IAW-1:0]      rg_addr, rg_next, rd_addr;
   logic [7:0]          rg_len;
   logic [1:0]          rg_burst;
   logic                rg_wrap_bad, rg_cur_in, rg_next_in;
   logic                ar_drop, ar_fire, r_fire, rd_en, rd_in;

   // Address generator sees the incoming request while idle, the latched burst otherwise
   always_comb begin
      wg_addr  = waddr_q;
      wg_len   = wlen_q;
      wg_burst = wburst_q;
      if (w_state_q == W_IDLE) begin
         wg_addr  = IAW'(awaddr_i);
         wg_len   = awlen_i;
         wg_burst = awburst_i;
      end
   end

   axi4_burst_addr_gen #(.IAW(IAW), .DEPTH(DEPTH)) u_wr_gen (
      .addr_i          (wg_addr),
      .len_i           (wg_len),
      .burst_i         (wg_burst),
      .next_addr_o     (wg_next),
      .wrap_illegal_o  (wg_wrap_bad),
      .cur_in_range_o  (wg_cur_in),
      .next_in_range_o (wg_next_in_unused)
   );

   assign aw_drop    = (awsize_i != 3'd2) || (awburst_i == 2'b11);
   assign w_fire     = (w_state_q == W_DATA) && wvalid_i && wready_q;
   assign w_en       = w_fire && !wdrop_q && !wpast_q && wg_cur_in;
   assign w_beat_err = (!wg_cur_in && !wpast_q) ||
                       (wlast_i && (wpast_q || (wbeat_q != wlen_q)));

   // Write FSM: AW capture, data beats, then a held B response
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         w_state_q <= W_IDLE;
         wid_q     <= '0;
         waddr_q   <= '0;
         wlen_q    <= '0;
         wbeat_q   <= '0;
         wburst_q  <= '0;
         bresp_q   <= RESP_OKAY;
         wdrop_q   <= 1'b0;
         wpast_q   <= 1'b0;
         werr_q    <= 1'b0;
         awready_q <= 1'b0;
         wready_q  <= 1'b0;
         bvalid_q  <= 1'b0;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               awready_q <= 1'b1;
               if (awvalid_i && awready_q) begin
                  awready_q <= 1'b0;
                  wready_q  <= 1'b1;
                  wid_q     <= awid_i;
                  waddr_q   <= wg_addr;
                  wlen_q    <= awlen_i;
                  wburst_q  <= awburst_i;
                  wbeat_q   <= '0;
                  wpast_q   <= 1'b0;
                  wdrop_q   <= aw_drop;
                  werr_q    <= aw_drop || wg_wrap_bad;
                  w_state_q <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_fire) begin
                  waddr_q <= wg_next;
                  wbeat_q <= wbeat_q + 8'd1;
                  if (wbeat_q == wlen_q) wpast_q <= 1'b1;
                  werr_q  <= werr_q || w_beat_err;
                  if (wlast_i) begin
                     wready_q  <= 1'b0;
                     bvalid_q  <= 1'b1;
                     bresp_q   <= (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
                     w_state_q <= W_RESP;
                  end
               end
            end
            W_RESP: begin
               if (bready_i) begin
                  bvalid_q  <= 1'b0;
                  awready_q <= 1'b1;
                  w_state_q <= W_IDLE;
               end
            end
            default: w_state_q <= W_IDLE;
         endcase
      end
   end

   // Read address generator: request address while idle, latched beat otherwise
   always_comb begin
      rg_addr  = raddr_q;
      rg_len   = rlen_q;
      rg_burst = rburst_q;
      if (r_state_q == R_IDLE) begin
         rg_addr  = IAW'(araddr_i);
         rg_len   = arlen_i;
         rg_burst = arburst_i;
      end
   end

   axi4_burst_addr_gen #(.IAW(IAW), .DEPTH(DEPTH)) u_rd_gen (
      .addr_i          (rg_addr),
      .len_i           (rg_len),
      .burst_i         (rg_burst),
      .next_addr_o     (rg_next),
      .wrap_illegal_o  (rg_wrap_bad),
      .cur_in_range_o  (rg_cur_in),
      .next_in_range_o (rg_next_in)
   );

   assign ar_drop = (arsize_i != 3'd2) || (arburst_i == 2'b11);
   assign ar_fire = (r_state_q == R_IDLE) && arvalid_i && arready_q;
   assign r_fire  = (r_state_q == R_DATA) && rvalid_q && rready_i;
   assign rd_addr = (r_state_q == R_IDLE) ? rg_addr : rg_next;
   assign rd_in   = (r_state_q == R_IDLE) ? rg_cur_in : rg_next_in;
   assign rd_en   = (ar_fire || (r_fire && !rlast_q)) && rd_in;

   // Read FSM: AR capture fetches beat 0, each R transfer prefetches the next beat
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         r_state_q <= R_IDLE;
         rid_q     <= '0;
         raddr_q   <= '0;
         rlen_q    <= '0;
         rbeat_q   <= '0;
         rburst_q  <= '0;
         rresp_q   <= RESP_OKAY;
         rdrop_q   <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         rzero_q   <= 1'b1;
         arready_q <= 1'b0;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               arready_q <= 1'b1;
               if (ar_fire) begin
                  arready_q <= 1'b0;
                  rid_q     <= arid_i;
                  raddr_q   <= rg_addr;
                  rlen_q    <= arlen_i;
                  rburst_q  <= arburst_i;
                  rbeat_q   <= '0;
                  rdrop_q   <= ar_drop;
                  rvalid_q  <= 1'b1;
                  rlast_q   <= (arlen_i == 8'd0);
                  rzero_q   <= ar_drop || !rg_cur_in;
                  rresp_q   <= (ar_drop || rg_wrap_bad || !rg_cur_in) ? RESP_SLVERR : RESP_OKAY;
                  r_state_q <= R_DATA;
               end
            end
            R_DATA: begin
               if (r_fire) begin
                  if (rlast_q) begin
                     rvalid_q  <= 1'b0;
                     rlast_q   <= 1'b0;
                     arready_q <= 1'b1;
                     r_state_q <= R_IDLE;
                  end else begin
                     raddr_q <= rg_next;
                     rbeat_q <= rbeat_q + 8'd1;
                     rlast_q <= ((rbeat_q + 8'd1) == rlen_q);
                     rzero_q <= rdrop_q || !rg_next_in;
                     rresp_q <= (rdrop_q || rg_wrap_bad || !rg_next_in) ? RESP_SLVERR : RESP_OKAY;
                  end
               end
            end
            default: r_state_q <= R_IDLE;
         endcase
      end
   end

   // Memory: byte-enabled write, registered read returning pre-write data on collision
   always_ff @(posedge clock_i) begin
      if (w_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb_i[b]) mem_q[waddr_q[IDX_W+1:2]][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
      if (rd_en) rd_word_q <= mem_q[rd_addr[IDX_W+1:2]];
   end

   assign awready_o = awready_q;
   assign wready_o  = wready_q;
   assign bid_o     = wid_q;
   assign bresp_o   = bresp_q;
   assign bvalid_o  = bvalid_q;
   assign arready_o = arready_q;
   assign rid_o     = rid_q;
   assign rdata_o   = rzero_q ? 32'd0 : rd_word_q;
   assign rresp_o   = rresp_q;
   assign rlast_o   = rlast_q;
   assign rvalid_o  = rvalid_q;
   assign w_state_o = w_state_q;
   assign r_state_o = r_state_q;

endmodule
